fifo_word_packer: RTL

//  Downstream consumer of the byte FIFO. Pops bytes with the FIFO's rd/empty interface.

---
 rtl/fifo_word_packer_if.sv | 39 +++
 rtl/fifo_word_packer.sv | 101 ++++++++++
 2 files changed

// File: rtl/fifo_word_packer_if.sv
// fifo_word_packer_if
//   Bundles the byte-FIFO read side and the packed-word output side of the
//   word packer.
//   Valid/ready rule for the word side: a word transfers on every rising edge
//   where word_valid && word_ready. Once word_valid rises it stays high, and
//   word_out/word_bytes stay stable, until that transfer happens.
//   FIFO side: fifo_rd is a request. It is accepted on an edge where
//   !fifo_empty, and the byte then arrives one cycle later with
//   fifo_data_valid.
//   Modports:
//     master : the packer (drives fifo_rd and word_*)
//     slave  : FIFO + downstream consumer (drives fifo_* inputs, flush, word_ready)
interface fifo_word_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4,
    parameter int CNT_WIDTH  = 3
);
    localparam int WORD_WIDTH = DATA_WIDTH * PACK_RATIO;

    logic                  fifo_empty;
    logic                  fifo_rd;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_data_valid;
    logic                  flush;
    logic [WORD_WIDTH-1:0] word_out;
    logic [CNT_WIDTH-1:0]  word_bytes;
    logic                  word_valid;
    logic                  word_ready;

    modport master (
        input  fifo_empty, fifo_data, fifo_data_valid, flush, word_ready,
        output fifo_rd, word_out, word_bytes, word_valid
    );

    modport slave (
        output fifo_empty, fifo_data, fifo_data_valid, flush, word_ready,
        input  fifo_rd, word_out, word_bytes, word_valid
    );
endinterface

// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//   Pops bytes from a FIFO that has one cycle of read latency. Packs
//   PACK_RATIO bytes into one word, first byte in the LSBs. Offers the word
//   on a valid/ready handshake. A flush releases a partial word; its unfilled
//   upper bytes are zero.
//   Ports:
//     clk        rising-edge clock
//     clear      asynchronous active-high reset; partial bytes are discarded
//     bus        fifo_word_packer_if.master (FIFO read side + word output side)
//     state_dbg  current FSM state (0 = COLLECT, 1 = HOLD)
module fifo_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                clk,
    input  logic                clear,
    fifo_word_packer_if.master  bus,
    output logic                state_dbg
);
    localparam int WORD_WIDTH = DATA_WIDTH * PACK_RATIO;
    localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(PACK_RATIO);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(PACK_RATIO - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  count;     // bytes captured into the current word
    logic                  pending;   // read accepted last edge, byte arrives this cycle
    logic [WORD_WIDTH-1:0] word_r;
    logic [CNT_WIDTH-1:0]  bytes_r;
    logic                  valid_r;

    logic [CNT_WIDTH-1:0]  in_flight;
    logic                  flush_go;
    logic                  rd;

    // Bytes already held plus the one still on its way from the FIFO. This
    // sum is compared with PACK_RATIO, so a word can never be overfilled.
    assign in_flight = count + CNT_WIDTH'(pending);

    // A flush waits for any outstanding byte. Then the partial word contains
    // every byte that has been popped.
    assign flush_go = bus.flush && (count != '0) && !pending;

    assign rd = !clear && (state == COLLECT) && !bus.fifo_empty
                && (in_flight < FULL) && !flush_go;

    assign bus.fifo_rd    = rd;
    assign bus.word_out   = word_r;
    assign bus.word_bytes = bytes_r;
    assign bus.word_valid = valid_r;
    assign state_dbg      = state;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state   <= COLLECT;
            count   <= '0;
            pending <= 1'b0;
            word_r  <= '0;
            bytes_r <= '0;
            valid_r <= 1'b0;
        end else begin
            // rd already includes !fifo_empty.
            pending <= rd;
            unique case (state)
                COLLECT: begin
                    if (bus.fifo_data_valid) begin
                        word_r[int'(count) * DATA_WIDTH +: DATA_WIDTH] <= bus.fifo_data;
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            state   <= HOLD;
                            valid_r <= 1'b1;
                            bytes_r <= FULL;
                        end
                    end else if (flush_go) begin
                        // Upper bytes are still zero from the last clear of word_r.
                        state   <= HOLD;
                        valid_r <= 1'b1;
                        bytes_r <= count;
                    end
                end
                HOLD: begin
                    // The byte FIFO cannot deliver here because fifo_rd is low.
                    // Any stray fifo_data_valid is therefore ignored.
                    if (bus.word_ready) begin
                        state   <= COLLECT;
                        valid_r <= 1'b0;
                        count   <= '0;
                        word_r  <= '0;
                        bytes_r <= '0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule
